fios_operand_server: RTL and testbench
======================================

# fios_operand_server

Host-side operand and result server for the FIOS Montgomery multiplier. It stores the A, B and P operands and the p'0 constant as 17-bit words. It answers the multiplier's `a_shift`/`b_fetch`/`p_fetch`/`RES_push`/`done` strobes by presenting operand words and capturing result words. It issues the multiplier start pulse and exposes the result to the host through a word-addressed read port.

## Interface
- `s`, 8: number of 17-bit words per operand.
- `PE_NB`, 8: number of PEs; width of the parallel A window in words.
- `clock_i` in 1: single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `load_valid_i` in 1: host write strobe.
- `load_sel_i` in 2: target; 0=A, 1=B, 2=P, 3=p'0 (address ignored).
- `load_addr_i` in $clog2(s): word index.
- `load_data_i` in 17: write data.
- `go_i` in 1: start request.
- `busy_o` out 1: multiplication in progress.
- `res_valid_o` out 1: result memory holds a complete result.
- `err_o` out 1: sticky protocol error.
- `res_rd_addr_i` in $clog2(s): host result read index.
- `res_rd_data_o` out 17: `RES[res_rd_addr_i]`, asynchronous read.
- `start_o` out 1: one-cycle start pulse to the multiplier.
- `p_prime_0_o` out 17: stored p'0.
- `a_o` out PE_NB*17: A window; bits [17k+16:17k] = `A[a_base+k]`, or 0 when `a_base+k >= s`.
- `b_o`, `p_o` out 17: `B[b_idx]`, `P[p_idx]`.
- `a_shift_i`, `b_fetch_i`, `p_fetch_i`, `RES_push_i`, `done_i` in 1: multiplier strobes.
- `RES_i` in 17: result word, valid when `RES_push_i` is high.

## Operation
- FSM states:
  - IDLE: go_i→START.
  - START: start_o=1, indices cleared, →RUN unconditionally.
  - RUN: done_i→DONE.
  - DONE: go_i→START.
- Loads are accepted in IDLE and DONE only. In START/RUN they are ignored and set err_o.
- go_i in START/RUN is ignored.
- `a_base` steps by PE_NB on each a_shift_i in RUN and saturates once ≥ s; the window then reads all zeros.
- `b_idx` increments on b_fetch_i and wraps s-1→0, because B is re-streamed every outer iteration. `p_idx` behaves identically on p_fetch_i.
- RES_push_i in RUN writes RES_i to `RES[res_idx]` and then increments res_idx.
  - A push with res_idx == s is dropped and sets err_o.
- done_i in RUN:
  - sets res_valid_o if res_idx == s, including the case where the final push arrives in the same cycle;
  - otherwise sets err_o and leaves res_valid_o low.
- Strobes outside RUN are ignored.
- res_valid_o clears on entering START.
- err_o clears only on reset or on entering START.
- Reset values: state IDLE; start_o, busy_o, res_valid_o and err_o are 0; all indices and a_base are 0. Memory contents are not reset.
- Reset mid-RUN aborts: the FSM returns to IDLE and later multiplier strobes are ignored.

## Timing
- go_i sampled at t → start_o high during t+1 only; busy_o high from t+1 until the cycle after done_i.
- Index updates are registered. A strobe at t makes the new b_o/p_o/a_o visible at t+1.
- The multiplier samples the current word in the strobe cycle.
- Host load at t → word visible on a_o/b_o/p_o/p_prime_0_o at t+1.
- A RES_push_i at t is readable on res_rd_data_o from t+1.
- done_i at t → res_valid_o high and busy_o low at t+1.
- Simultaneous strobes are all honoured in the same cycle, including b_fetch_i with p_fetch_i and RES_push_i with done_i.

## Structure
- Package `fios_if_pkg`:
  - `WORD_W = 17`;
  - `load_sel_t` enum (SEL_A, SEL_B, SEL_P, SEL_PP0);
  - `srv_state_t` enum (IDLE, START, RUN, DONE).
- Sub-module `fios_word_bank` (param DEPTH; sync write, asynchronous read) is instantiated for B, P and RES.
- A is a flat register array with PE_NB generate-indexed read ports.

## Test plan
- Load s=8 words, A=k+1, B=0x100+k, P=0x1FFFF-k, p'0=0x0ABCD. Check a_o[16:0]=1, b_o=0x100, p_o=0x1FFFF, p_prime_0_o=0x0ABCD.
- go_i at t → start_o only at t+1, busy_o=1. Pulse b_fetch_i 9 times → b_o steps 0x101…0x107, wraps to 0x100, then 0x101.
- PE_NB=3, s=8: a_shift_i ×3 → window words {4,5,6}, {7,8,0}, all zero. A further shift stays all zero.
- 8 RES_push_i with RES_i=0x10+k, done_i on the 8th push cycle → res_valid_o=1 next cycle, err_o=0. Reading addr 5 gives 0x15.
- 9th push, or done_i after only 7 pushes → err_o=1, res_valid_o=0. A subsequent go_i clears err_o.
- reset_i mid-RUN after 3 pushes → IDLE, busy_o=0. Strobes are ignored until go_i, and the new run restarts at res_idx 0. A load during RUN → err_o=1 and memory unchanged.

Source files
------------

// File: rtl/fios_if_pkg.sv
// Shared types for the FIOS operand server: word width, load target select and server FSM states.
package fios_if_pkg;

   localparam int unsigned WORD_W = 17;

   typedef enum logic [1:0] {
      SEL_A   = 2'd0,
      SEL_B   = 2'd1,
      SEL_P   = 2'd2,
      SEL_PP0 = 2'd3
   } load_sel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } srv_state_t;

endpackage

// File: rtl/fios_word_bank.sv
// Small word memory: synchronous write, asynchronous read. Used for B, P and RES.
module fios_word_bank
   import fios_if_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WORD_W-1:0]        i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WORD_W-1:0]        o_rdata
);

   logic [WORD_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fios_operand_server.sv
// Host-side operand/result server for the FIOS Montgomery multiplier: holds A/B/P/p'0,
// serves words on multiplier strobes, captures result words and sequences start/done.
module fios_operand_server
   import fios_if_pkg::*;
#(
   parameter int unsigned s     = 8,
   parameter int unsigned PE_NB = 8
) (
   input  logic                      clock_i,
   input  logic                      reset_i,
   input  logic                      load_valid_i,
   input  logic [1:0]                load_sel_i,
   input  logic [$clog2(s)-1:0]      load_addr_i,
   input  logic [WORD_W-1:0]         load_data_i,
   input  logic                      go_i,
   output logic                      busy_o,
   output logic                      res_valid_o,
   output logic                      err_o,
   input  logic [$clog2(s)-1:0]      res_rd_addr_i,
   output logic [WORD_W-1:0]         res_rd_data_o,
   output logic                      start_o,
   output logic [WORD_W-1:0]         p_prime_0_o,
   output logic [PE_NB*WORD_W-1:0]   a_o,
   output logic [WORD_W-1:0]         b_o,
   output logic [WORD_W-1:0]         p_o,
   input  logic                      a_shift_i,
   input  logic                      b_fetch_i,
   input  logic                      p_fetch_i,
   input  logic                      RES_push_i,
   input  logic                      done_i,
   input  logic [WORD_W-1:0]         RES_i
);

   localparam int unsigned AW = $clog2(s);
   localparam int unsigned CW = $clog2(s + 1);
   localparam int unsigned BW = $clog2(s + PE_NB);

   srv_state_t        r_state;
   logic [WORD_W-1:0] r_a [s];
   logic [WORD_W-1:0] r_pp0;
   logic [AW-1:0]     r_b_idx;
   logic [AW-1:0]     r_p_idx;
   logic [BW-1:0]     r_a_base;
   logic [CW-1:0]     r_res_idx;
   logic              r_res_valid;
   logic              r_err;

   load_sel_t w_sel;
   logic      w_run;
   logic      w_load_ok;
   logic      w_res_we;
   logic      w_res_full;

   assign w_sel     = load_sel_t'(load_sel_i);
   assign w_run     = (r_state == RUN);
   assign w_load_ok = (r_state == IDLE) || (r_state == DONE);
   assign w_res_we  = w_run && RES_push_i && (r_res_idx < CW'(s));
   // A push landing in the done cycle still counts toward a complete result.
   assign w_res_full = (r_res_idx == CW'(s)) || (w_res_we && (r_res_idx == CW'(s - 1)));

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state     <= IDLE;
         r_b_idx     <= '0;
         r_p_idx     <= '0;
         r_a_base    <= '0;
         r_res_idx   <= '0;
         r_res_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (go_i) begin
                  r_state     <= START;
                  r_b_idx     <= '0;
                  r_p_idx     <= '0;
                  r_a_base    <= '0;
                  r_res_idx   <= '0;
                  r_res_valid <= 1'b0;
                  r_err       <= 1'b0;
               end
            end
            START: r_state <= RUN;
            RUN: begin
               if (a_shift_i && (r_a_base < BW'(s))) r_a_base <= r_a_base + BW'(PE_NB);
               if (b_fetch_i) r_b_idx <= (r_b_idx == AW'(s - 1)) ? '0 : r_b_idx + 1'b1;
               if (p_fetch_i) r_p_idx <= (r_p_idx == AW'(s - 1)) ? '0 : r_p_idx + 1'b1;
               if (w_res_we) r_res_idx <= r_res_idx + 1'b1;
               if (RES_push_i && !w_res_we) r_err <= 1'b1;
               if (done_i) begin
                  r_state <= DONE;
                  if (w_res_full) r_res_valid <= 1'b1;
                  else            r_err       <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
         if (load_valid_i && !w_load_ok) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (load_valid_i && w_load_ok) begin
         if (w_sel == SEL_A)   r_a[load_addr_i] <= load_data_i;
         if (w_sel == SEL_PP0) r_pp0            <= load_data_i;
      end
   end

   fios_word_bank #(.DEPTH(s)) u_bank_b (
      .i_clk   (clock_i),
      .i_we    (load_valid_i && w_load_ok && (w_sel == SEL_B)),
      .i_waddr (load_addr_i),
      .i_wdata (load_data_i),
      .i_raddr (r_b_idx),
      .o_rdata (b_o)
   );

   fios_word_bank #(.DEPTH(s)) u_bank_p (
      .i_clk   (clock_i),
      .i_we    (load_valid_i && w_load_ok && (w_sel == SEL_P)),
      .i_waddr (load_addr_i),
      .i_wdata (load_data_i),
      .i_raddr (r_p_idx),
      .o_rdata (p_o)
   );

   fios_word_bank #(.DEPTH(s)) u_bank_res (
      .i_clk   (clock_i),
      .i_we    (w_res_we),
      .i_waddr (r_res_idx[AW-1:0]),
      .i_wdata (RES_i),
      .i_raddr (res_rd_addr_i),
      .o_rdata (res_rd_data_o)
   );

   for (genvar k = 0; k < PE_NB; k++) begin : g_win
      logic [BW:0] w_idx;
      assign w_idx = {1'b0, r_a_base} + (BW + 1)'(k);
      assign a_o[WORD_W*k +: WORD_W] = (w_idx < (BW + 1)'(s)) ? r_a[w_idx[AW-1:0]] : '0;
   end

   assign busy_o      = (r_state == START) || (r_state == RUN);
   assign start_o     = (r_state == START);
   assign res_valid_o = r_res_valid;
   assign err_o       = r_err;
   assign p_prime_0_o = r_pp0;

endmodule

// File: tb/tb_fios_operand_server.sv
// Directed-plus-random bench for fios_operand_server against a counting reference model.
module tb_fios_operand_server;

   localparam int unsigned S  = 8;
   localparam int unsigned PE = 3;
   localparam int unsigned AW = 3;

   logic              clock_i = 1'b0;
   logic              reset_i = 1'b1;
   logic              load_valid_i = 1'b0;
   logic [1:0]        load_sel_i = '0;
   logic [AW-1:0]     load_addr_i = '0;
   logic [16:0]       load_data_i = '0;
   logic              go_i = 1'b0;
   logic              busy_o, res_valid_o, err_o, start_o;
   logic [AW-1:0]     res_rd_addr_i = '0;
   logic [16:0]       res_rd_data_o, p_prime_0_o, b_o, p_o;
   logic [PE*17-1:0]  a_o;
   logic              a_shift_i = 1'b0, b_fetch_i = 1'b0, p_fetch_i = 1'b0;
   logic              RES_push_i = 1'b0, done_i = 1'b0;
   logic [16:0]       RES_i = '0;

   always #10 clock_i = ~clock_i;

   fios_operand_server #(.s(S), .PE_NB(PE)) dut (
      .clock_i(clock_i), .reset_i(reset_i),
      .load_valid_i(load_valid_i), .load_sel_i(load_sel_i),
      .load_addr_i(load_addr_i), .load_data_i(load_data_i),
      .go_i(go_i), .busy_o(busy_o), .res_valid_o(res_valid_o), .err_o(err_o),
      .res_rd_addr_i(res_rd_addr_i), .res_rd_data_o(res_rd_data_o),
      .start_o(start_o), .p_prime_0_o(p_prime_0_o), .a_o(a_o), .b_o(b_o), .p_o(p_o),
      .a_shift_i(a_shift_i), .b_fetch_i(b_fetch_i), .p_fetch_i(p_fetch_i),
      .RES_push_i(RES_push_i), .done_i(done_i), .RES_i(RES_i)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: memories plus strobe counters; index values derived arithmetically.
   logic [16:0] mA [S];
   logic [16:0] mB [S];
   logic [16:0] mP [S];
   logic [16:0] mRes [S];
   logic [16:0] mPP0;
   bit m_run, m_err, m_valid;
   int nb, np, nsh, nres;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   function automatic logic [PE*17-1:0] exp_win();
      logic [PE*17-1:0] w = '0;
      for (int k = 0; k < PE; k++) begin
         int idx = nsh * PE + k;
         if (idx < S) w[17*k +: 17] = mA[idx];
      end
      return w;
   endfunction

   task automatic check_outs(input string tag);
      chk({tag, ".b"},     64'(b_o),         64'(mB[nb % S]));
      chk({tag, ".p"},     64'(p_o),         64'(mP[np % S]));
      chk({tag, ".a"},     64'(a_o),         64'(exp_win()));
      chk({tag, ".pp0"},   64'(p_prime_0_o), 64'(mPP0));
      chk({tag, ".err"},   64'(err_o),       64'(m_err));
      chk({tag, ".valid"}, 64'(res_valid_o), 64'(m_valid));
      chk({tag, ".busy"},  64'(busy_o),      64'(m_run));
   endtask

   task automatic load(input int sel, input int addr, input logic [16:0] d);
      logic [31:0] a32 = 32'(addr);
      load_valid_i = 1'b1;
      load_sel_i   = 2'(sel);
      load_addr_i  = a32[AW-1:0];
      load_data_i  = d;
      step();
      load_valid_i = 1'b0;
      if (m_run) m_err = 1'b1;
      else begin
         case (sel)
            0: mA[addr] = d;
            1: mB[addr] = d;
            2: mP[addr] = d;
            default: mPP0 = d;
         endcase
      end
   endtask

   task automatic cyc(input bit push, input logic [16:0] rd, input bit bf, input bit pf,
                      input bit as, input bit dn);
      RES_push_i = push; RES_i = rd; b_fetch_i = bf; p_fetch_i = pf; a_shift_i = as; done_i = dn;
      step();
      RES_push_i = 1'b0; b_fetch_i = 1'b0; p_fetch_i = 1'b0; a_shift_i = 1'b0; done_i = 1'b0;
      if (m_run) begin
         nb += int'(bf);
         np += int'(pf);
         nsh += int'(as);
         if (push) begin
            if (nres < S) begin
               mRes[nres] = rd;
               nres++;
            end else m_err = 1'b1;
         end
         if (dn) begin
            if (nres == S) m_valid = 1'b1;
            else           m_err = 1'b1;
            m_run = 1'b0;
         end
      end
   endtask

   task automatic go(input string tag);
      go_i = 1'b1;
      step();
      go_i = 1'b0;
      m_run = 1'b1; nb = 0; np = 0; nsh = 0; nres = 0; m_err = 1'b0; m_valid = 1'b0;
      chk({tag, ".start1"}, 64'(start_o),     64'(1));
      chk({tag, ".busyS"},  64'(busy_o),      64'(1));
      chk({tag, ".errclr"}, 64'(err_o),       64'(0));
      chk({tag, ".valclr"}, 64'(res_valid_o), 64'(0));
      step();
      chk({tag, ".start0"}, 64'(start_o),     64'(0));
      check_outs({tag, ".run"});
   endtask

   task automatic chk_res(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         res_rd_addr_i = AW'(i);
         #1;
         chk($sformatf("%s.res%0d", tag, i), 64'(res_rd_data_o), 64'(mRes[i]));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_run = 0; m_err = 0; m_valid = 0; nb = 0; np = 0; nsh = 0; nres = 0;
      reset_i = 1'b1;
      step(); step();
      reset_i = 1'b0;
      chk("rst.start", 64'(start_o),     64'(0));
      chk("rst.busy",  64'(busy_o),      64'(0));
      chk("rst.valid", 64'(res_valid_o), 64'(0));
      chk("rst.err",   64'(err_o),       64'(0));

      for (int k = 0; k < S; k++) begin
         load(0, k, 17'(k + 1));
         load(1, k, 17'(32'h100 + k));
         load(2, k, 17'(32'h1FFFF - k));
      end
      load(3, 0, 17'h0ABCD);
      chk("ld.a0",  64'(a_o[16:0]),  64'(17'h1));
      chk("ld.b0",  64'(b_o),        64'(17'h100));
      chk("ld.p0",  64'(p_o),        64'(17'h1FFFF));
      chk("ld.pp0", 64'(p_prime_0_o), 64'(17'h0ABCD));
      check_outs("ld");

      // Run 1: fetch wrap, window saturation, complete result.
      go("r1");
      go_i = 1'b1; step(); go_i = 1'b0;
      chk("r1.go_ignored", 64'(start_o), 64'(0));
      for (int i = 0; i < 9; i++) begin
         cyc(0, '0, 1, 1'($urandom), 0, 0);
         check_outs($sformatf("r1.bf%0d", i));
      end
      for (int i = 0; i < 4; i++) begin
         cyc(0, '0, 0, 0, 1, 0);
         check_outs($sformatf("r1.sh%0d", i));
      end
      for (int k = 0; k < S; k++) cyc(1, 17'(32'h10 + k), 0, 0, 0, k == S - 1);
      check_outs("r1.done");
      chk_res("r1", S);
      res_rd_addr_i = 3'd5; #1;
      chk("r1.rd5", 64'(res_rd_data_o), 64'(17'h15));

      // Run 2: overflow push is dropped and flagged.
      go("r2");
      for (int k = 0; k < S + 1; k++) begin
         cyc(1, 17'($urandom), 0, 0, 0, 0);
         check_outs($sformatf("r2.push%0d", k));
      end
      chk_res("r2", S);
      cyc(0, '0, 0, 0, 0, 1);
      check_outs("r2.done");

      // Run 3: early done with one word missing.
      go("r3");
      for (int k = 0; k < S - 1; k++) cyc(1, 17'($urandom), 1'($urandom), 1'($urandom), 0, k == S - 2);
      check_outs("r3.done");

      // Run 4: load during RUN, then reset mid-run, then a clean restart.
      go("r4");
      load(1, 0, 17'($urandom));
      check_outs("r4.ldrun");
      for (int k = 0; k < 3; k++) cyc(1, 17'($urandom), 0, 0, 0, 0);
      reset_i = 1'b1; step(); reset_i = 1'b0;
      m_run = 0; m_err = 0; m_valid = 0; nb = 0; np = 0; nsh = 0; nres = 0;
      check_outs("r4.rst");
      for (int i = 0; i < 4; i++) begin
         cyc(1'($urandom), 17'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         check_outs($sformatf("r4.ign%0d", i));
      end
      chk_res("r4.keep", 3);
      load(2, 0, 17'($urandom));
      load(0, 1, 17'($urandom));
      check_outs("r4.ldidle");
      go("r5");
      for (int k = 0; k < S; k++) cyc(1, 17'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), k == S - 1);
      check_outs("r5.done");
      chk_res("r5", S);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
